image_frame_gen: RTL and testbench

Parametrised, synthesisable pixel-frame stimulus source for the image filter environment, sitting on the testbench side and driving the filter's pixel input interface in place of hand-poked scalar stimulus. Generates complete frames of IMG_W x IMG_H pixels, each carrying CH channels of DATA_W bits, over a valid/ready stream. Provides selectable test patterns, frame/line markers, horizontal and vertical blanking, multi-frame runs, abort, and backpressure handling.

---
 rtl/image_frame_gen_if.sv | 29 ++
 rtl/image_frame_gen.sv | 255 +++++++++++++++++++++++++
 tb/tb_image_frame_gen.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/image_frame_gen_if.sv
// image_frame_gen_if
// Pixel stream bundle between the frame generator and its consumer.
// Ports (master view):
//   o_valid  out  pixel valid
//   o_data   out  PIX_W-bit pixel, channel c at [c*DATA_W +: DATA_W]
//   o_sof    out  first pixel of frame
//   o_eol    out  last pixel of line
//   o_eof    out  last pixel of frame
//   i_ready  in   downstream ready
interface image_frame_gen_if #(
  parameter int PIX_W = 8
);
  logic             o_valid;
  logic [PIX_W-1:0] o_data;
  logic             o_sof;
  logic             o_eol;
  logic             o_eof;
  logic             i_ready;

  modport master (
    output o_valid, o_data, o_sof, o_eol, o_eof,
    input  i_ready
  );

  modport slave (
    input  o_valid, o_data, o_sof, o_eol, o_eof,
    output i_ready
  );
endinterface

// File: rtl/image_frame_gen.sv
// image_frame_gen
// Pixel-frame stimulus source: emits frames of IMG_W x IMG_H pixels (CH
// channels of DATA_W bits) on a valid/ready stream with selectable test
// patterns, sof/eol/eof markers, horizontal/vertical blanking, multi-frame
// runs and abort.
// Ports:
//   clk, rstn   clock; asynchronous active-high reset
//   i_start     start pulse (IDLE only)
//   i_stop      synchronous abort from any busy state
//   i_mode      pattern select, latched at start
//   i_const     constant for mode 0, latched at start
//   i_frames    frames per run, latched at start (0 = continuous)
//   pix         pixel stream (master side of image_frame_gen_if)
//   o_busy      high whenever not IDLE
//   o_done      one-cycle pulse at the end of a finite run
module image_frame_gen #(
  parameter int DATA_W = 8,
  parameter int CH     = 1,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int HBLANK = 4,
  parameter int VBLANK = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic [1:0]           i_mode,
  input  logic [DATA_W-1:0]    i_const,
  input  logic [7:0]           i_frames,
  image_frame_gen_if.master    pix,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int BMAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  localparam int BW   = (BMAX > 0) ? $clog2(BMAX + 1) : 1;
  localparam int PW   = CH * DATA_W;

  localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
  localparam logic [BW-1:0] HB_LAST = BW'((HBLANK > 0) ? HBLANK - 1 : 0);
  localparam logic [BW-1:0] VB_LAST = BW'((VBLANK > 0) ? VBLANK - 1 : 0);

  typedef enum logic [1:0] {IDLE, ACTIVE, HBL, VBL} state_t;

  state_t              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [7:0]          frame_q, frame_d;
  logic [BW-1:0]       blank_q, blank_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   const_q, const_d;
  logic [7:0]          frames_q, frames_d;
  logic                valid_q, valid_d;
  logic [PW-1:0]       data_q, data_d;
  logic                sof_q, sof_d;
  logic                eol_q, eol_d;
  logic                eof_q, eof_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                beat;
  logic                load_pix;
  logic                quiet;
  logic [7:0]          frame_inc;

  // Pixel value for coordinate (px, py) of frame pf under the given pattern.
  function automatic logic [PW-1:0] pixel_at(
    input logic [1:0]        mode,
    input logic [DATA_W-1:0] cval,
    input logic [XW-1:0]     px,
    input logic [YW-1:0]     py,
    input logic [7:0]        pf
  );
    logic [PW-1:0]     pix_v;
    logic [DATA_W-1:0] ch_v;
    logic [31:0]       cb;
    pix_v = '0;
    cb    = (32'(px) >> 3) ^ (32'(py) >> 3);
    for (int c = 0; c < CH; c++) begin
      case (mode)
        2'd0:    ch_v = cval;
        2'd1:    ch_v = DATA_W'(px) + DATA_W'(c);
        2'd2:    ch_v = {DATA_W{cb[0]}};
        default: ch_v = DATA_W'(px) + DATA_W'(py) + DATA_W'(pf) + DATA_W'(c);
      endcase
      pix_v[c*DATA_W +: DATA_W] = ch_v;
    end
    return pix_v;
  endfunction

  // Next-state logic. Output registers are reloaded only when a new pixel is
  // presented (load_pix) or the stream goes quiet, so they hold across
  // backpressure without any combinational path from i_ready to the outputs.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    frame_d   = frame_q;
    blank_d   = blank_q;
    mode_d    = mode_q;
    const_d   = const_q;
    frames_d  = frames_q;
    valid_d   = valid_q;
    data_d    = data_q;
    sof_d     = sof_q;
    eol_d     = eol_q;
    eof_d     = eof_q;
    done_d    = 1'b0;
    load_pix  = 1'b0;
    quiet     = 1'b0;
    frame_inc = frame_q + 8'd1;
    beat      = valid_q & pix.i_ready;

    case (state_q)
      IDLE: begin
        if (i_start && !i_stop) begin
          state_d  = ACTIVE;
          x_d      = '0;
          y_d      = '0;
          frame_d  = '0;
          mode_d   = i_mode;
          const_d  = i_const;
          frames_d = i_frames;
          load_pix = 1'b1;
        end
      end
      ACTIVE: begin
        if (beat) begin
          if (x_q != X_LAST) begin
            x_d      = x_q + 1'b1;
            load_pix = 1'b1;
          end else begin
            x_d = '0;
            if (y_q != Y_LAST) begin
              y_d = y_q + 1'b1;
              if (HBLANK == 0) begin
                load_pix = 1'b1;
              end else begin
                state_d = HBL;
                blank_d = '0;
                quiet   = 1'b1;
              end
            end else begin
              y_d = '0;
              if ((frames_q != 8'd0) && (frame_inc == frames_q)) begin
                state_d = IDLE;
                done_d  = 1'b1;
                quiet   = 1'b1;
              end else begin
                frame_d = frame_inc;
                if (VBLANK == 0) begin
                  load_pix = 1'b1;
                end else begin
                  state_d = VBL;
                  blank_d = '0;
                  quiet   = 1'b1;
                end
              end
            end
          end
        end
      end
      HBL: begin
        if (blank_q == HB_LAST) begin
          state_d  = ACTIVE;
          load_pix = 1'b1;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end
      VBL: begin
        if (blank_q == VB_LAST) begin
          state_d  = ACTIVE;
          load_pix = 1'b1;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything, including a beat in the same cycle.
    if ((state_q != IDLE) && i_stop) begin
      state_d  = IDLE;
      done_d   = 1'b0;
      load_pix = 1'b0;
      quiet    = 1'b1;
    end

    if (load_pix) begin
      valid_d = 1'b1;
      data_d  = pixel_at(mode_d, const_d, x_d, y_d, frame_d);
      sof_d   = (x_d == '0) && (y_d == '0);
      eol_d   = (x_d == X_LAST);
      eof_d   = (x_d == X_LAST) && (y_d == Y_LAST);
    end else if (quiet) begin
      valid_d = 1'b0;
      data_d  = '0;
      sof_d   = 1'b0;
      eol_d   = 1'b0;
      eof_d   = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      frame_q  <= '0;
      blank_q  <= '0;
      mode_q   <= '0;
      const_q  <= '0;
      frames_q <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      sof_q    <= 1'b0;
      eol_q    <= 1'b0;
      eof_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      frame_q  <= frame_d;
      blank_q  <= blank_d;
      mode_q   <= mode_d;
      const_q  <= const_d;
      frames_q <= frames_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      sof_q    <= sof_d;
      eol_q    <= eol_d;
      eof_q    <= eof_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign pix.o_valid = valid_q;
  assign pix.o_data  = data_q;
  assign pix.o_sof   = sof_q;
  assign pix.o_eol   = eol_q;
  assign pix.o_eof   = eof_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_image_frame_gen.sv
// tb_image_frame_gen
// Directed self-checking bench. DUT A: 4x2 frame, 3 channels, HBLANK=2,
// VBLANK=3. DUT B: 16x2 frame, 1 channel, used for the checkerboard pattern.
module tb_image_frame_gen;

  logic       clk     = 1'b0;
  logic       rstn    = 1'b1;
  logic       start   = 1'b0;
  logic       start_b = 1'b0;
  logic       stop    = 1'b0;
  logic [1:0] mode    = 2'd0;
  logic [7:0] cval    = 8'd0;
  logic [7:0] frames  = 8'd0;
  logic       busy, done, busy_b, done_b;

  int checks = 0;
  int errors = 0;

  image_frame_gen_if #(.PIX_W(24)) pix_a ();
  image_frame_gen_if #(.PIX_W(8))  pix_b ();

  always #5 clk = ~clk;

  image_frame_gen #(
    .DATA_W(8), .CH(3), .IMG_W(4), .IMG_H(2), .HBLANK(2), .VBLANK(3)
  ) dut_a (
    .clk(clk), .rstn(rstn), .i_start(start), .i_stop(stop), .i_mode(mode),
    .i_const(cval), .i_frames(frames), .pix(pix_a), .o_busy(busy), .o_done(done)
  );

  image_frame_gen #(
    .DATA_W(8), .CH(1), .IMG_W(16), .IMG_H(2), .HBLANK(1), .VBLANK(1)
  ) dut_b (
    .clk(clk), .rstn(rstn), .i_start(start_b), .i_stop(stop), .i_mode(mode),
    .i_const(cval), .i_frames(frames), .pix(pix_b), .o_busy(busy_b), .o_done(done_b)
  );

  // {sof, eol, eof, data} of DUT A as one word
  logic [26:0] obs_a;
  assign obs_a = {pix_a.o_sof, pix_a.o_eol, pix_a.o_eof, pix_a.o_data};

  // Mode 1, 3 channels: {x+2, x+1, x} for x = 0..3
  logic [23:0] line_data [4] = '{24'h020100, 24'h030201, 24'h040302, 24'h050403};

  // Expected {sof, eol, eof, data} of beat i in a mode-1 single-frame run.
  function automatic logic [26:0] exp_beat(input int i);
    int x;
    x = i % 4;
    return {(i == 0), (x == 3), (i == 7), line_data[x]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic sp, input logic [1:0] md,
                               input logic [7:0] cv, input logic [7:0] fr, input logic rd);
    start         = st;
    stop          = sp;
    mode          = md;
    cval          = cv;
    frames        = fr;
    pix_a.i_ready = rd;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    int         bi, beats, f, xx, yy, s;
    int         eof1_cyc, sof2_cyc, b16_cyc, done_cyc;
    bit         act, got_done, rdy;
    logic [26:0] expected;

    pix_a.i_ready = 1'b1;
    pix_b.i_ready = 1'b1;

    // Reset state
    #2;
    checkOutput("reset_outputs", {pix_a.o_valid, busy, done, obs_a}, '0);
    @(negedge clk);
    rstn = 1'b0;
    tick();
    tick();

    // Test 1: mode 1, one frame, ready always high
    $display("[TB] test 1: single frame, mode 1");
    applyStimulus(1, 0, 2'd1, 8'h00, 8'd1, 1);
    tick();
    applyStimulus(0, 0, 2'd1, 8'h00, 8'd1, 1);
    for (int cyc = 1; cyc <= 11; cyc++) begin
      act = ((cyc >= 1) && (cyc <= 4)) || ((cyc >= 7) && (cyc <= 10));
      bi  = (cyc <= 4) ? cyc - 1 : cyc - 3;
      checkOutput("t1_valid", pix_a.o_valid, act);
      if (act) checkOutput("t1_beat", obs_a, exp_beat(bi));
      checkOutput("t1_done", done, (cyc == 11));
      checkOutput("t1_busy", busy, (cyc != 11));
      tick();
    end

    // Test 2: same run with ready toggling 1,0,1,0
    $display("[TB] test 2: backpressure");
    applyStimulus(1, 0, 2'd1, 8'h00, 8'd1, 1);
    tick();
    beats    = 0;
    got_done = 0;
    for (int n = 0; n < 40 && !got_done; n++) begin
      rdy = (n % 2 == 0);
      applyStimulus(0, 0, 2'd1, 8'h00, 8'd1, rdy);
      if (pix_a.o_valid) checkOutput("t2_hold", obs_a, exp_beat(beats));
      if (pix_a.o_valid && rdy) beats++;
      if (done) got_done = 1;
      tick();
    end
    checkOutput("t2_beats", beats, 8);
    checkOutput("t2_done_seen", got_done, 1);

    // Test 3: mode 3, two frames
    $display("[TB] test 3: two frames, mode 3");
    applyStimulus(1, 0, 2'd3, 8'h00, 8'd2, 1);
    tick();
    applyStimulus(0, 0, 2'd3, 8'h00, 8'd2, 1);
    beats    = 0;
    eof1_cyc = -1;
    sof2_cyc = -1;
    b16_cyc  = -1;
    done_cyc = -1;
    for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
      if (pix_a.o_valid) begin
        f  = beats / 8;
        yy = (beats / 4) % 2;
        xx = beats % 4;
        s  = xx + yy + f;
        expected = {(beats % 8 == 0), (xx == 3), (beats % 8 == 7),
                    8'(s + 2), 8'(s + 1), 8'(s)};
        checkOutput("t3_beat", obs_a, expected);
        if (beats == 7) eof1_cyc = cyc;
        if (beats == 8) begin
          sof2_cyc = cyc;
          checkOutput("t3_f2_ch0", pix_a.o_data[7:0], 8'd1);
        end
        if (beats == 15) b16_cyc = cyc;
        beats++;
      end
      if (done) done_cyc = cyc;
      tick();
    end
    checkOutput("t3_beats", beats, 16);
    checkOutput("t3_vblank_gap", sof2_cyc - eof1_cyc - 1, 3);
    checkOutput("t3_done_cycle", done_cyc, b16_cyc + 1);

    // Test 4: reset in the middle of a frame
    $display("[TB] test 4: reset mid-frame");
    applyStimulus(1, 0, 2'd1, 8'h00, 8'd1, 1);
    tick();
    applyStimulus(0, 0, 2'd1, 8'h00, 8'd1, 1);
    for (int n = 0; n < 7; n++) tick();
    checkOutput("t4_pre_reset", obs_a, exp_beat(5));
    #2;
    rstn = 1'b1;
    #1;
    checkOutput("t4_async_reset", {pix_a.o_valid, busy, done, obs_a}, '0);
    @(negedge clk);
    rstn = 1'b0;
    tick();
    checkOutput("t4_idle", {pix_a.o_valid, busy}, 2'b00);
    applyStimulus(1, 0, 2'd1, 8'h00, 8'd1, 1);
    tick();
    applyStimulus(0, 0, 2'd1, 8'h00, 8'd1, 1);
    checkOutput("t4_restart", {pix_a.o_valid, pix_a.o_sof, pix_a.o_data[7:0]},
                {1'b1, 1'b1, 8'h00});
    for (int n = 0; n < 12; n++) tick();

    // Test 5: continuous run, ignored start, stop in HBL
    $display("[TB] test 5: continuous run, stop");
    applyStimulus(1, 0, 2'd1, 8'h00, 8'd0, 1);
    tick();
    applyStimulus(0, 0, 2'd1, 8'h00, 8'd0, 1);
    tick();
    applyStimulus(1, 0, 2'd0, 8'hAA, 8'd0, 1);
    tick();
    applyStimulus(0, 0, 2'd1, 8'h00, 8'd0, 1);
    checkOutput("t5_start_ignored", obs_a, {3'b000, 24'h040302});
    tick();
    checkOutput("t5_eol", obs_a, {3'b010, 24'h050403});
    tick();
    checkOutput("t5_hbl", {pix_a.o_valid, busy}, 2'b01);
    applyStimulus(0, 1, 2'd1, 8'h00, 8'd0, 1);
    tick();
    applyStimulus(0, 0, 2'd1, 8'h00, 8'd0, 1);
    checkOutput("t5_stopped", {pix_a.o_valid, busy, done}, 3'b000);
    tick();
    checkOutput("t5_no_done", {pix_a.o_valid, busy, done}, 3'b000);
    applyStimulus(1, 1, 2'd1, 8'h00, 8'd0, 1);
    tick();
    applyStimulus(0, 0, 2'd1, 8'h00, 8'd0, 1);
    checkOutput("t5_start_stop_idle", {pix_a.o_valid, busy}, 2'b00);

    // Test 6: checkerboard on a 16-wide single-channel frame
    $display("[TB] test 6: mode 2 checkerboard");
    applyStimulus(0, 0, 2'd2, 8'h00, 8'd1, 1);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int x = 0; x < 16; x++) begin
      checkOutput("t6_pix", {pix_b.o_valid, pix_b.o_sof, pix_b.o_eol, pix_b.o_data},
                  {1'b1, (x == 0), (x == 15), ((x >= 8) ? 8'hFF : 8'h00)});
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
